// File: rtl/ecc_sed_enc_arbiter_if.sv
// Bundle of requester, encoder and output-stage signals for the shared SED encoder arbiter.
// The arbiter uses the slave view; the client/encoder/sink side uses the master view.
interface ecc_sed_enc_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 12,
    parameter int IDW  = $clog2(NREQ)
);
    logic                     cfg_mode;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0][DW-1:0]  req_data;
    logic [NREQ-1:0]          req_ready;
    logic [DW-1:0]            enc_data;
    logic                     enc_data_valid;
    logic [DW:0]              enc_codeword;
    logic                     enc_valid;
    logic                     out_valid;
    logic [DW:0]              out_codeword;
    logic [IDW-1:0]           out_id;
    logic                     out_ready;
    logic                     enc_err;
    logic [15:0]              word_cnt;

    modport master (
        output cfg_mode, req_valid, req_data, enc_codeword, enc_valid, out_ready,
        input  req_ready, enc_data, enc_data_valid, out_valid, out_codeword, out_id,
               enc_err, word_cnt
    );

    modport slave (
        input  cfg_mode, req_valid, req_data, enc_codeword, enc_valid, out_ready,
        output req_ready, enc_data, enc_data_valid, out_valid, out_codeword, out_id,
               enc_err, word_cnt
    );
endinterface

// File: rtl/ecc_sed_enc_arbiter.sv
// Arbitrates NREQ requesters onto one SED parity encoder and registers the
// codeword plus requester id behind a valid/ready stage; flags encoder inconsistency.
module ecc_sed_enc_arbiter_lane #(
    parameter int DW = 12
) (
    input  logic          gnt,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] data_gated
);
    assign data_gated = gnt ? data : '0;
endmodule

module ecc_sed_enc_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 12,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_sed_enc_arbiter_if.slave  bus
);
    localparam int PW = IDW + 1;

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [DW:0]    codeword;
        logic [IDW-1:0] id;
    } out_t;

    state_t                  state_q, state_d;
    out_t                    out_q, out_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                    err_q, err_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [IDW-1:0]          gnt_id;
    logic                    any_req, can_accept, accept;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0][DW-1:0] lane_data;
    logic [DW-1:0]           enc_data_or;

    // Rotated search: fixed priority is just a search that always starts at 0.
    always_comb begin
        logic [PW-1:0] idx;
        gnt_id  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = bus.cfg_mode ? PW'(k) : {1'b0, rr_ptr_q} + PW'(k);
            if (idx >= PW'(NREQ)) idx = idx - PW'(NREQ);
            if (!any_req && bus.req_valid[idx[IDW-1:0]]) begin
                any_req = 1'b1;
                gnt_id  = idx[IDW-1:0];
            end
        end
    end

    // rst gating keeps req_ready low for the whole reset assertion.
    assign can_accept = rst && (state_q == EMPTY || bus.out_ready);
    assign accept     = can_accept && any_req;
    assign gnt        = accept ? (NREQ'(1) << gnt_id) : '0;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        ecc_sed_enc_arbiter_lane #(.DW(DW)) u_lane (
            .gnt        (gnt[i]),
            .data       (bus.req_data[i]),
            .data_gated (lane_data[i])
        );
    end

    always_comb begin
        enc_data_or = '0;
        for (int i = 0; i < NREQ; i++) enc_data_or |= lane_data[i];
    end

    assign bus.req_ready      = gnt;
    assign bus.enc_data       = enc_data_or;
    assign bus.enc_data_valid = accept;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (accept) begin
            state_d  = FULL;
            out_d    = '{codeword: bus.enc_codeword, id: gnt_id};
            rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            cnt_d    = cnt_q + 16'd1;
        end else if (state_q == FULL && bus.out_ready) begin
            state_d = EMPTY;
        end
        // Parity bit is deliberately not checked; only the data echo and valid pairing.
        if (bus.enc_valid != accept) err_d = 1'b1;
        if (accept && bus.enc_codeword[DW-1:0] != enc_data_or) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EMPTY;
            out_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_valid    = (state_q == FULL);
    assign bus.out_codeword = out_q.codeword;
    assign bus.out_id       = out_q.id;
    assign bus.enc_err      = err_q;
    assign bus.word_cnt     = cnt_q;
endmodule

// File: tb/tb_ecc_sed_enc_arbiter.sv
// Scoreboard bench for ecc_sed_enc_arbiter: a reference model predicts grants and
// pushes expected codewords; a monitor pops them as words leave the output stage.
module tb_ecc_sed_enc_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic corrupt_en = 1'b0;
    logic spur_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ecc_sed_enc_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    ecc_sed_enc_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural encoder with two injectable faults.
    assign bus.enc_codeword = (corrupt_en && bus.enc_data == 12'h055) ? 13'h0000
                                                                      : {^bus.enc_data, bus.enc_data};
    assign bus.enc_valid    = bus.enc_data_valid ^ spur_valid;

    typedef struct {
        logic [DW:0] cw;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   rd_idx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Winner = valid requester at the smallest distance from the start point.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr, input logic mode);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                int d = mode ? i : (i - ptr + NREQ) % NREQ;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    // Reference model.
    logic        m_full = 1'b0;
    int          m_rr   = 0;
    logic [15:0] m_cnt  = '0;
    logic        m_err  = 1'b0;

    always @(negedge clk) begin
        int              g;
        logic            acc;
        logic [DW-1:0]   d;
        logic [DW:0]     cw;
        logic [NREQ-1:0] exp_rdy;
        if (!rst) begin
            m_full = 1'b0; m_rr = 0; m_cnt = '0; m_err = 1'b0;
        end else begin
            g   = pick(bus.req_valid, m_rr, bus.cfg_mode);
            acc = (!m_full || bus.out_ready) && g >= 0;
            d   = acc ? bus.req_data[g] : '0;
            exp_rdy = '0;
            if (acc) exp_rdy[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("enc_data_valid", bus.enc_data_valid, acc);
            chk("enc_data", bus.enc_data, d);
            chk("out_valid", bus.out_valid, m_full);
            chk("word_cnt", bus.word_cnt, m_cnt);
            chk("enc_err", bus.enc_err, m_err);
            if (spur_valid || (acc && corrupt_en && d == 12'h055)) m_err = 1'b1;
            if (acc) begin
                if (corrupt_en && d == 12'h055) cw = '0;
                else cw = {($countones(d) % 2) == 1, d};
                exp_q.push_back('{cw: cw, id: g});
                m_rr   = (g + 1) % NREQ;
                m_cnt  = m_cnt + 16'd1;
                m_full = 1'b1;
            end else if (m_full && bus.out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: every word leaving the output stage must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            rd_idx = exp_q.size();
        end else if (bus.out_valid && bus.out_ready) begin
            chk("out_pending", rd_idx < exp_q.size(), 1'b1);
            if (rd_idx < exp_q.size()) begin
                chk("out_codeword", bus.out_codeword, exp_q[rd_idx].cw);
                chk("out_id", bus.out_id, exp_q[rd_idx].id);
                rd_idx++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    logic [DW:0] rr_cw [5];
    int          rr_id [5];

    initial begin
        rr_cw = '{13'h0003, 13'h1007, 13'h000F, 13'h0000, 13'h0003};
        rr_id = '{0, 1, 2, 3, 0};
        bus.cfg_mode  = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_codeword", bus.out_codeword, 13'h0000);
        chk("rst_word_cnt", bus.word_cnt, 16'h0000);
        chk("rst_enc_err", bus.enc_err, 1'b0);
        rst = 1'b1;

        // Single word from requester 0.
        bus.req_valid = 4'b0001;
        bus.req_data[0] = 12'h001;
        bus.out_ready = 1'b1;
        #1 chk("d1_req_ready", bus.req_ready, 4'b0001);
        cyc();
        bus.req_valid = '0;
        chk("d1_out_valid", bus.out_valid, 1'b1);
        chk("d1_out_codeword", bus.out_codeword, 13'h1001);
        chk("d1_out_id", bus.out_id, 0);
        chk("d1_word_cnt", bus.word_cnt, 16'd1);

        // Round-robin over four always-valid requesters.
        do_reset();
        bus.req_data  = {12'h000, 12'h00F, 12'h007, 12'h003};
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr_out_id", bus.out_id, rr_id[k]);
            chk("rr_out_codeword", bus.out_codeword, rr_cw[k]);
        end

        // Fixed priority: requester 0 always wins.
        bus.cfg_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("fp_out_id", bus.out_id, 0);
            chk("fp_out_codeword", bus.out_codeword, 13'h0003);
        end
        bus.cfg_mode = 1'b0;

        // Backpressure hold, then drain and accept on the same edge.
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_data[2] = 12'hABC;
        bus.out_ready = 1'b0;
        cyc();
        bus.req_data[2] = 12'h123;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_req_ready", bus.req_ready, 4'b0000);
            cyc();
            chk("hold_out_codeword", bus.out_codeword, 13'h1ABC);
            chk("hold_out_id", bus.out_id, 2);
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.req_valid = '0;
        chk("swap_out_valid", bus.out_valid, 1'b1);
        chk("swap_out_codeword", bus.out_codeword, 13'h0123);

        // Encoder data corruption sets a sticky error.
        do_reset();
        corrupt_en = 1'b1;
        bus.req_valid = 4'b0010;
        bus.req_data[1] = 12'h055;
        cyc();
        bus.req_valid = '0;
        corrupt_en = 1'b0;
        chk("corrupt_out_codeword", bus.out_codeword, 13'h0000);
        for (int k = 0; k < 3; k++) begin
            chk("err_sticky", bus.enc_err, 1'b1);
            cyc();
        end
        do_reset();
        chk("err_cleared", bus.enc_err, 1'b0);
        spur_valid = 1'b1;
        cyc();
        spur_valid = 1'b0;
        chk("spur_err", bus.enc_err, 1'b1);
        cyc();
        chk("spur_err_sticky", bus.enc_err, 1'b1);
        do_reset();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) bus.req_data[i] = DW'($urandom);
            bus.cfg_mode  = ($urandom % 4) == 0;
            bus.out_ready = ($urandom % 4) != 0;
            cyc();
        end

        // Exactly 65536 accepts after reset wrap the counter to zero.
        do_reset();
        bus.cfg_mode  = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 65536; k++) begin
            bus.req_data[k % NREQ] = DW'($urandom);
            cyc();
        end
        bus.req_valid = '0;
        chk("wrap_word_cnt", bus.word_cnt, 16'h0000);

        // Asynchronous reset mid-stream.
        bus.req_valid = 4'b1111;
        cyc();
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 1'b0);
        chk("async_out_codeword", bus.out_codeword, 13'h0000);
        chk("async_out_id", bus.out_id, 0);
        chk("async_word_cnt", bus.word_cnt, 16'h0000);
        chk("async_req_ready", bus.req_ready, 4'b0000);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();

        // Drain: every predicted word must have been observed.
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (rd_idx == exp_q.size()) break;
            cyc();
        end
        chk("drain_all_seen", rd_idx == exp_q.size(), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ecc_sed_enc_arbiter.md
# ecc_sed_enc_arbiter

Shares one single-error-detect (SED) parity encoder among NREQ requesters. Each requester offers a 12-bit data word with a valid/ready handshake. The arbiter grants one requester per cycle and drives the encoder's `data`/`data_valid` inputs. It captures the 13-bit codeword plus the requester ID into a registered output stage with valid/ready backpressure, and checks the encoder's response for consistency. It sits between the producer clients and the downstream storage/link that consumes SED codewords.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 12, data width; codeword width is DW+1
- IDW, $clog2(NREQ), width of the requester ID

Ports:
- clk  input  1  clock; all logic is rising-edge triggered
- rst  input  1  reset, asynchronous, active-low (rst=0 resets)
- cfg_mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins); sampled every cycle
- req_valid  input  NREQ  per-requester word offered
- req_data  input  NREQ*DW  requester i occupies bits [i*DW +: DW]
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- enc_data  output  DW  word to the encoder (granted word, else 0)
- enc_data_valid  output  1  high in the cycle a word is accepted
- enc_codeword  input  DW+1  encoder result; combinational with enc_data; bit DW is parity
- enc_valid  input  1  encoder valid; must equal enc_data_valid in the same cycle
- out_valid  output  1  output register holds a codeword
- out_codeword  output  DW+1  registered codeword
- out_id  output  IDW  index of the requester that produced out_codeword
- out_ready  input  1  downstream accepts when out_valid & out_ready
- enc_err  output  1  sticky encoder-consistency error
- word_cnt  output  16  count of words accepted; wraps 0xFFFF to 0x0000

## Operation
- The output stage has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = EMPTY, or (FULL & out_ready).
- Grant is combinational, and only when can_accept:
  - Round-robin: the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ.
  - Fixed priority: the lowest i with req_valid[i].
- req_ready[g]=1 only for the granted g; all other bits are 0.
- A requester with req_valid=0 is never granted.
- Accept = req_valid[g] & req_ready[g]. On accept:
  - enc_data = req_data[g] and enc_data_valid = 1.
  - At the clock edge, out_codeword <= enc_codeword, out_id <= g, and the stage goes to (or stays) FULL.
  - rr_ptr <= (g+1) mod NREQ.
  - word_cnt increments.
- rr_ptr updates only on an accept, and also updates in fixed-priority mode, so switching modes is seamless.
- FULL & out_ready & no request: the stage goes EMPTY at the edge.
- FULL & !out_ready: out_codeword and out_id hold stable, and all req_ready bits are 0.
- enc_err is set at the edge, and stays set until reset, when either condition holds:
  - enc_valid != enc_data_valid in any cycle.
  - On an accept, enc_codeword[DW-1:0] != enc_data.
- The parity bit is not checked.
- Capture into the output stage is not suppressed when enc_err is set.

## Timing
- Reset (rst=0, asynchronous) drives:
  - out_valid=0, out_codeword=0, out_id=0.
  - rr_ptr=0, enc_err=0, word_cnt=0.
- req_ready is 0 while reset is asserted.
- Latency: a word accepted at edge N is presented on out_valid/out_codeword from edge N onward (one register stage).
- Throughput: one word per cycle while out_ready=1.
- Simultaneous drain and accept in the FULL state: the old word leaves and the new word is loaded at the same edge; out_valid stays 1.
- Reset asserted mid-transfer: the word in the output register is dropped, and no accept is recorded in that cycle.
- cfg_mode changes take effect in the same cycle's grant.

## Test plan
- Reset, then requester 0 offers 0x001 with out_ready=1 -> req_ready=0001; the next cycle out_valid=1, out_codeword=0x1001, out_id=0, word_cnt=1.
- All 4 requesters valid continuously (data 0x003, 0x007, 0x00F, 0x000), cfg_mode=0, out_ready=1 -> grant order 0,1,2,3,0; codewords 0x0003, 0x1007, 0x0F, 0x0000.
- Same stimulus with cfg_mode=1 -> requester 0 granted every cycle; out_id stays 0.
- Requester 2 offers 0xABC, out_ready=0 for 3 cycles -> out_valid=1, the register holds 0x0ABC (or its parity variant) stable, req_ready=0000; when out_ready rises, the drain and the next accept happen in the same cycle.
- Encoder model returns enc_codeword[11:0]=0x000 for data 0x055, or drives enc_valid with no grant -> enc_err=1 from the next cycle; it stays 1 until rst=0.
- 65536 accepted words -> word_cnt wraps to 0; rst=0 asserted mid-stream -> all outputs return to 0 immediately, asynchronously.
